// File: rtl/branch_hazard_ctrl.sv
// Branch and hazard controller for a non-forwarding 5-stage pipeline.
// Tracks in-flight register writers, stalls ID on RAW hazards, and resolves
// control-flow instructions in EX. Prediction is static not-taken, so a taken
// redirect flushes the wrong-path instructions.
module branch_hazard_ctrl #(
  parameter int NREG = 32,
  parameter int CNTW = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_id_valid,
  input  logic        i_id_is_branch,
  input  logic        i_id_is_jal,
  input  logic        i_id_is_jalr,
  input  logic [2:0]  i_id_funct3,
  input  logic [4:0]  i_id_rs1_addr,
  input  logic [4:0]  i_id_rs2_addr,
  input  logic        i_id_rs1_used,
  input  logic        i_id_rs2_used,
  input  logic [4:0]  i_id_rd_addr,
  input  logic        i_id_rd_wren,
  input  logic [4:0]  i_wb_rd_addr,
  input  logic        i_wb_rd_wren,
  input  logic        i_br_less,
  input  logic        i_br_equal,
  output logic        o_br_un,
  output logic        o_stall,
  output logic        o_flush_id,
  output logic        o_flush_ex,
  output logic        o_pc_sel,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
);

  // ex_kind bit positions
  localparam int KindBranch = 0;
  localparam int KindJal    = 1;
  localparam int KindJalr   = 2;

  logic [CNTW-1:0] busy_cnt [NREG];
  logic [NREG-1:0] sb_inc;
  logic [NREG-1:0] sb_dec;

  logic            ex_ctl_valid;
  logic [2:0]      ex_kind;
  logic [2:0]      ex_funct3;

  logic            br_cond;
  logic            br_taken;
  logic            rs1_hazard;
  logic            rs2_hazard;
  logic            issue;
  logic            inc_en;
  logic            dec_en;
  logic [CNTW-1:0] rs1_cnt;
  logic [CNTW-1:0] rs2_cnt;

  // Branch decision for the control-flow instruction currently in EX
  always_comb begin
    br_cond = 1'b0;
    case (ex_funct3)
      3'b000:  br_cond = i_br_equal;
      3'b001:  br_cond = ~i_br_equal;
      3'b100:  br_cond = i_br_less;
      3'b101:  br_cond = ~i_br_less;
      3'b110:  br_cond = i_br_less;
      3'b111:  br_cond = ~i_br_less;
      default: br_cond = 1'b0;
    endcase
    br_taken = ex_ctl_valid & (ex_kind[KindJal] | ex_kind[KindJalr] |
                               (ex_kind[KindBranch] & br_cond));
  end

  // RAW hazard detection; a sole writer retiring this cycle is covered by
  // the write-through register file
  always_comb begin
    rs1_cnt    = busy_cnt[i_id_rs1_addr];
    rs2_cnt    = busy_cnt[i_id_rs2_addr];
    rs1_hazard = i_id_rs1_used && (i_id_rs1_addr != 5'd0) && (rs1_cnt != '0) &&
                 !((rs1_cnt == CNTW'(1)) && i_wb_rd_wren && (i_wb_rd_addr == i_id_rs1_addr));
    rs2_hazard = i_id_rs2_used && (i_id_rs2_addr != 5'd0) && (rs2_cnt != '0) &&
                 !((rs2_cnt == CNTW'(1)) && i_wb_rd_wren && (i_wb_rd_addr == i_id_rs2_addr));
  end

  // Pipeline control outputs; flush takes priority over stall
  always_comb begin
    o_stall    = i_id_valid & (rs1_hazard | rs2_hazard) & ~br_taken;
    o_flush_id = br_taken;
    o_flush_ex = br_taken;
    o_pc_sel   = br_taken;
    o_br_un    = ex_ctl_valid & ex_funct3[1];
    issue      = i_id_valid & ~o_stall & ~o_flush_id;
  end

  // Per-register increment/decrement requests
  always_comb begin
    inc_en = issue & i_id_rd_wren & (i_id_rd_addr != 5'd0);
    dec_en = i_wb_rd_wren & (i_wb_rd_addr != 5'd0);
    sb_inc = '0;
    sb_dec = '0;
    for (int r = 0; r < NREG; r++) begin
      sb_inc[r] = inc_en && (i_id_rd_addr == 5'(r));
      sb_dec[r] = dec_en && (i_wb_rd_addr == 5'(r));
    end
  end

  // Scoreboard of in-flight writers; simultaneous inc and dec cancel
  always_ff @(posedge i_clk) begin
    for (int r = 0; r < NREG; r++) begin
      if (i_reset) begin
        busy_cnt[r] <= '0;
      end else if (sb_inc[r] && !sb_dec[r]) begin
        busy_cnt[r] <= busy_cnt[r] + CNTW'(1);
      end else if (sb_dec[r] && !sb_inc[r]) begin
        busy_cnt[r] <= busy_cnt[r] - CNTW'(1);
      end
    end
  end

  // EX-stage control-flow tracking; stalls and flushes insert a bubble
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ex_ctl_valid <= 1'b0;
      ex_kind      <= 3'b000;
      ex_funct3    <= 3'b000;
    end else begin
      ex_ctl_valid <= issue & (i_id_is_branch | i_id_is_jal | i_id_is_jalr);
      ex_kind      <= {i_id_is_jalr, i_id_is_jal, i_id_is_branch};
      ex_funct3    <= i_id_funct3;
    end
  end

  // Performance counters, wrapping modulo 2^32
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      if (o_stall)  o_stall_cnt <= o_stall_cnt + 32'd1;
      if (br_taken) o_flush_cnt <= o_flush_cnt + 32'd1;
    end
  end

endmodule
